// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer pixel writer.
//   - FSM state encodings (plain 4-bit constants, legacy compatible)
//   - Slot layout: big-endian bit offsets relative to the start of a slot
package fb_pkg;

  localparam int unsigned SLOT_W       = 64;
  localparam int unsigned VALID_BIT    = 0;
  localparam int unsigned LINE_MSB_OFS = 15;
  localparam int unsigned COL_MSB_OFS  = 31;
  localparam int unsigned COLOR_OFS    = 32;
  localparam int unsigned COLOR_W      = 32;

  typedef logic [3:0] fb_state_t;

  localparam fb_state_t ST_IDLE       = 4'd0;
  localparam fb_state_t ST_FETCH      = 4'd1;
  localparam fb_state_t ST_LATCH      = 4'd2;
  localparam fb_state_t ST_SCAN       = 4'd3;
  localparam fb_state_t ST_REQ        = 4'd4;
  localparam fb_state_t ST_REARB      = 4'd5;
  localparam fb_state_t ST_WAIT_CMPLT = 4'd6;
  localparam fb_state_t ST_ERR_RST    = 4'd7;
  localparam fb_state_t ST_ERR_REC    = 4'd8;
  localparam fb_state_t ST_ADV        = 4'd9;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// PLB IPIF master bus bundle used by fb_pixel_writer.
//   master modport : the write master (drives IP2Bus_*, samples Bus2IP_*)
//   slave  modport : the IPIF side (drives Bus2IP_*, samples IP2Bus_*)
interface fb_pixel_writer_if #(
  parameter int unsigned C_MST_AWIDTH = 32,
  parameter int unsigned C_MST_DWIDTH = 32
);

  logic                        IP2Bus_MstRd_Req;
  logic                        IP2Bus_MstWr_Req;
  logic [0:C_MST_AWIDTH-1]     IP2Bus_Mst_Addr;
  logic [0:C_MST_DWIDTH/8-1]   IP2Bus_Mst_BE;
  logic                        IP2Bus_Mst_Lock;
  logic                        IP2Bus_Mst_Reset;
  logic [0:C_MST_DWIDTH-1]     IP2Bus_MstWr_d;

  logic                        Bus2IP_Mst_CmdAck;
  logic                        Bus2IP_Mst_Cmplt;
  logic                        Bus2IP_Mst_Error;
  logic                        Bus2IP_Mst_Rearbitrate;
  logic                        Bus2IP_Mst_Cmd_Timeout;
  logic [0:C_MST_DWIDTH-1]     Bus2IP_MstRd_d;
  logic                        Bus2IP_MstRd_src_rdy_n;
  logic                        Bus2IP_MstWr_dst_rdy_n;

  modport master (
    output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
           Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d,
           Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
  );

  modport slave (
    input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
           Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d,
           Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
  );

endinterface

// File: rtl/fb_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-high reset to zero
//   inc   : count up by one this cycle
//   count : current value
module fb_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write master. Pops packed pixel words from the rasterizer FIFO,
// clips every valid slot against the framebuffer, and issues each surviving
// pixel as a single-beat PLB IPIF master write with bounded retry.
//   PLB_clk, reset : clock, synchronous active-high reset
//   fifo_data      : packed word, slot k at bits k*SLOT_W .. k*SLOT_W+SLOT_W-1
//   fifo_empty     : FIFO empty flag
//   fifo_rd_en     : one-cycle pop strobe
//   bus            : IPIF master bundle (master modport)
//   busy           : high whenever the FSM is not idle
//   pix_written    : saturating count of completed writes
//   pix_dropped    : saturating count of clipped and retry-exhausted pixels
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned PIX_PER_WORD = 2,
  parameter int unsigned LINE_LEN     = 9,
  parameter int unsigned COL_LEN      = 10,
  parameter int unsigned FB_WIDTH     = 640,
  parameter int unsigned FB_HEIGHT    = 480,
  parameter int unsigned C_MST_AWIDTH = 32,
  parameter int unsigned C_MST_DWIDTH = 32,
  parameter logic [C_MST_AWIDTH-LINE_LEN-COL_LEN-3:0] FB_BASE_ADDR = 11'b1001_0000_000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                          PLB_clk,
  input  logic                          reset,
  input  logic [0:PIX_PER_WORD*SLOT_W-1] fifo_data,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  fb_pixel_writer_if.master             bus,
  output logic                          busy,
  output logic [0:31]                   pix_written,
  output logic [0:15]                   pix_dropped
);

  localparam int unsigned IDX_W   = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  fb_state_t                      state;
  logic [0:PIX_PER_WORD*SLOT_W-1] word_reg;
  logic [IDX_W-1:0]               idx;
  logic [RETRY_W-1:0]             retry;
  logic [LINE_LEN-1:0]            line_r;
  logic [COL_LEN-1:0]             col_r;
  logic [COLOR_W-1:0]             color_r;

  logic [0:SLOT_W-1]   slot;
  logic                slot_valid;
  logic [LINE_LEN-1:0] slot_line;
  logic [COL_LEN-1:0]  slot_col;
  logic [COLOR_W-1:0]  slot_color;
  logic                slot_clip;
  logic                bus_fail;
  logic                retry_left;
  logic                written_inc;
  logic                dropped_inc;
  logic [31:0]         written_cnt;
  logic [15:0]         dropped_cnt;

  // Slot fields are big-endian; ascending part selects keep the first bit as MSB.
  assign slot       = word_reg[idx*SLOT_W +: SLOT_W];
  assign slot_valid = slot[VALID_BIT];
  assign slot_line  = slot[LINE_MSB_OFS-LINE_LEN+1 +: LINE_LEN];
  assign slot_col   = slot[COL_MSB_OFS-COL_LEN+1 +: COL_LEN];
  assign slot_color = slot[COLOR_OFS +: COLOR_W];
  assign slot_clip  = (32'(slot_line) >= FB_HEIGHT) || (32'(slot_col) >= FB_WIDTH);

  assign bus_fail   = bus.Bus2IP_Mst_Error || bus.Bus2IP_Mst_Cmd_Timeout;
  assign retry_left = (retry < RETRY_W'(MAX_RETRY));

  always_ff @(posedge PLB_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      word_reg <= '0;
      idx      <= '0;
      retry    <= '0;
      line_r   <= '0;
      col_r    <= '0;
      color_r  <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (!fifo_empty) state <= ST_FETCH;
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          word_reg <= fifo_data;
          idx      <= '0;
          state    <= ST_SCAN;
        end
        ST_SCAN: begin
          if (slot_valid && !slot_clip) begin
            line_r  <= slot_line;
            col_r   <= slot_col;
            color_r <= slot_color;
            retry   <= '0;
            state   <= ST_REQ;
          end else begin
            state <= ST_ADV;
          end
        end
        ST_REQ: begin
          if (bus_fail)                                              state <= ST_ERR_RST;
          else if (bus.Bus2IP_Mst_Rearbitrate)                       state <= ST_REARB;
          else if (bus.Bus2IP_Mst_CmdAck && bus.Bus2IP_Mst_Cmplt)    state <= ST_ADV;
          else if (bus.Bus2IP_Mst_CmdAck)                            state <= ST_WAIT_CMPLT;
        end
        ST_REARB: state <= ST_REQ;
        ST_WAIT_CMPLT: begin
          if (bus_fail)                  state <= ST_ERR_RST;
          else if (bus.Bus2IP_Mst_Cmplt) state <= ST_ADV;
        end
        ST_ERR_RST: state <= ST_ERR_REC;
        ST_ERR_REC: begin
          if (retry_left) begin
            retry <= retry + 1'b1;
            state <= ST_REQ;
          end else begin
            state <= ST_ADV;
          end
        end
        ST_ADV: begin
          if (idx == IDX_W'(PIX_PER_WORD - 1)) begin
            state <= ST_IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_SCAN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Completion in REQ only counts when no higher-priority status is present.
  always_comb begin
    written_inc = 1'b0;
    dropped_inc = 1'b0;
    case (state)
      ST_REQ:        written_inc = !bus_fail && !bus.Bus2IP_Mst_Rearbitrate &&
                                   bus.Bus2IP_Mst_CmdAck && bus.Bus2IP_Mst_Cmplt;
      ST_WAIT_CMPLT: written_inc = !bus_fail && bus.Bus2IP_Mst_Cmplt;
      ST_SCAN:       dropped_inc = slot_valid && slot_clip;
      ST_ERR_REC:    dropped_inc = !retry_left;
      default: begin
        written_inc = 1'b0;
        dropped_inc = 1'b0;
      end
    endcase
  end

  fb_sat_counter #(.WIDTH(32)) u_written (
    .clk   (PLB_clk),
    .rst   (reset),
    .inc   (written_inc),
    .count (written_cnt)
  );

  fb_sat_counter #(.WIDTH(16)) u_dropped (
    .clk   (PLB_clk),
    .rst   (reset),
    .inc   (dropped_inc),
    .count (dropped_cnt)
  );

  assign pix_written = written_cnt;
  assign pix_dropped = dropped_cnt;

  assign fifo_rd_en           = (state == ST_FETCH);
  assign busy                 = (state != ST_IDLE);
  assign bus.IP2Bus_MstRd_Req = 1'b0;
  assign bus.IP2Bus_MstWr_Req = (state == ST_REQ);
  assign bus.IP2Bus_Mst_Addr  = {FB_BASE_ADDR, line_r, col_r, 2'b00};
  assign bus.IP2Bus_Mst_BE    = '1;
  assign bus.IP2Bus_Mst_Lock  = 1'b0;
  assign bus.IP2Bus_Mst_Reset = reset || (state == ST_ERR_RST);
  assign bus.IP2Bus_MstWr_d   = color_r;

  logic unused_bus;
  assign unused_bus = ^{bus.Bus2IP_MstRd_d, bus.Bus2IP_MstRd_src_rdy_n,
                        bus.Bus2IP_MstWr_dst_rdy_n};

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: a FIFO model feeds words, a bus
// responder follows a per-attempt policy queue, and a scoreboard of expected
// writes is compared at every request attempt.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int unsigned PPW = 2, LL = 9, CL = 10, AW = 32, DW = 32, MAXR = 3;
  localparam int unsigned WORD_W = PPW * SLOT_W;
  localparam int K_OK = 0, K_ERR = 1, K_TO = 2, K_REARB = 3;
  localparam int B_IDLE = 0, B_REQ = 1, B_WAIT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [0:WORD_W-1] fifo_data = '0;
  logic fifo_empty = 1'b1;
  logic fifo_rd_en, busy;
  logic [0:31] pix_written;
  logic [0:15] pix_dropped;
  logic sc_rst = 1'b1, sc_inc = 1'b0;
  logic [3:0] sc_count;

  fb_pixel_writer_if #(.C_MST_AWIDTH(AW), .C_MST_DWIDTH(DW)) bus_if ();

  fb_pixel_writer #(
    .PIX_PER_WORD(PPW), .LINE_LEN(LL), .COL_LEN(CL), .FB_WIDTH(640), .FB_HEIGHT(480),
    .C_MST_AWIDTH(AW), .C_MST_DWIDTH(DW), .FB_BASE_ADDR(11'b1001_0000_000), .MAX_RETRY(MAXR)
  ) dut (
    .PLB_clk(clk), .reset(reset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .bus(bus_if), .busy(busy),
    .pix_written(pix_written), .pix_dropped(pix_dropped)
  );

  fb_sat_counter #(.WIDTH(4)) u_sc (.clk(clk), .rst(sc_rst), .inc(sc_inc), .count(sc_count));

  always #5 clk = ~clk;

  typedef struct { int kind; int ack_at; int gap; } pol_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;

  pol_t pol_q[$];
  exp_t exp_q[$];
  logic [0:WORD_W-1] fifo_q[$];
  int att_times[$];

  int checks = 0, failures = 0;
  int cyc_n = 0, bstate = B_IDLE, req_cyc = 0, cmplt_cnt = 0;
  pol_t cur;
  int exp_written = 0, exp_dropped = 0, fails_in_row = 0;
  int rd_pulses = 0, rst_pulses = 0, wr_cycles = 0, attempts = 0;
  int last_cmplt_t = 0, idle_t = 0;
  logic [AW-1:0] last_att_addr;
  logic [DW-1:0] last_att_data;

  function automatic logic [AW-1:0] make_addr(input int l, input int c);
    return {11'b1001_0000_000, 9'(l), 10'(c), 2'b00};
  endfunction

  function automatic logic [0:SLOT_W-1] make_slot(input logic v, input int l, input int c,
                                                  input logic [31:0] color);
    logic [0:SLOT_W-1] s;
    s = '0;
    s[VALID_BIT] = v;
    s[1 +: 6] = 6'h2A;  // ignored bits, deliberately non-zero
    s[LINE_MSB_OFS-LL+1 +: LL] = LL'(l);
    s[COL_MSB_OFS-CL+1 +: CL] = CL'(c);
    s[COLOR_OFS +: 32] = color;
    return s;
  endfunction

  task automatic add_word(input logic v0, input int l0, input int c0, input logic [31:0] d0,
                          input logic v1, input int l1, input int c1, input logic [31:0] d1);
    logic [0:WORD_W-1] w;
    logic v[2];
    int l[2], c[2];
    logic [31:0] d[2];
    v[0] = v0; l[0] = l0; c[0] = c0; d[0] = d0;
    v[1] = v1; l[1] = l1; c[1] = c1; d[1] = d1;
    for (int k = 0; k < 2; k++) begin
      w[k*SLOT_W +: SLOT_W] = make_slot(v[k], l[k], c[k], d[k]);
      if (v[k]) begin
        if (l[k] >= 480 || c[k] >= 640) exp_dropped++;
        else exp_q.push_back('{addr: make_addr(l[k], c[k]), data: d[k]});
      end
    end
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic pixel_failed();
    fails_in_row++;
    if (fails_in_row == MAXR + 1) begin
      exp_dropped++;
      void'(exp_q.pop_front());
      fails_in_row = 0;
    end
  endtask

  task automatic pixel_done();
    void'(exp_q.pop_front());
    exp_written++;
    fails_in_row = 0;
    last_cmplt_t = cyc_n;
  endtask

  // One clock of FIFO model, bus responder and scoreboard, run at the negedge.
  task automatic step();
    @(negedge clk);
    cyc_n++;
    bus_if.Bus2IP_Mst_CmdAck = 1'b0;
    bus_if.Bus2IP_Mst_Cmplt = 1'b0;
    bus_if.Bus2IP_Mst_Error = 1'b0;
    bus_if.Bus2IP_Mst_Cmd_Timeout = 1'b0;
    bus_if.Bus2IP_Mst_Rearbitrate = 1'b0;
    if (fifo_rd_en) begin
      rd_pulses++;
      checks++;
      if (fifo_q.size() == 0) begin
        failures++;
        $display("FAIL fifo_pop_when_empty got=1 exp=0");
      end else begin
        fifo_data = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
    end
    if (bus_if.IP2Bus_Mst_Reset) rst_pulses++;
    if (bus_if.IP2Bus_MstWr_Req) wr_cycles++;
    if (bstate == B_IDLE && bus_if.IP2Bus_MstWr_Req) begin
      attempts++;
      att_times.push_back(cyc_n);
      last_att_addr = bus_if.IP2Bus_Mst_Addr;
      last_att_data = bus_if.IP2Bus_MstWr_d;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_request addr=%h", bus_if.IP2Bus_Mst_Addr);
      end else if (bus_if.IP2Bus_Mst_Addr !== exp_q[0].addr || bus_if.IP2Bus_MstWr_d !== exp_q[0].data ||
                   bus_if.IP2Bus_Mst_BE !== 4'hF || bus_if.IP2Bus_MstRd_Req !== 1'b0 ||
                   bus_if.IP2Bus_Mst_Lock !== 1'b0) begin
        failures++;
        $display("FAIL request_fields addr=%h data=%h be=%h exp_addr=%h exp_data=%h",
                 bus_if.IP2Bus_Mst_Addr, bus_if.IP2Bus_MstWr_d, bus_if.IP2Bus_Mst_BE,
                 exp_q[0].addr, exp_q[0].data);
      end
      if (pol_q.size() > 0) cur = pol_q.pop_front();
      else cur = '{K_OK, 1, 0};
      req_cyc = 0;
      bstate = B_REQ;
    end
    if (bstate == B_REQ) begin
      if (!bus_if.IP2Bus_MstWr_Req) begin
        checks++;
        failures++;
        $display("FAIL req_withdrawn got=0 exp=1");
        bstate = B_IDLE;
      end else begin
        req_cyc++;
        case (cur.kind)
          K_ERR:   begin bus_if.Bus2IP_Mst_Error = 1'b1; pixel_failed(); bstate = B_IDLE; end
          K_TO:    begin bus_if.Bus2IP_Mst_Cmd_Timeout = 1'b1; pixel_failed(); bstate = B_IDLE; end
          K_REARB: begin bus_if.Bus2IP_Mst_Rearbitrate = 1'b1; bstate = B_IDLE; end
          default: begin
            if (req_cyc == cur.ack_at) begin
              bus_if.Bus2IP_Mst_CmdAck = 1'b1;
              if (cur.gap == 0) begin
                bus_if.Bus2IP_Mst_Cmplt = 1'b1;
                pixel_done();
                bstate = B_IDLE;
              end else begin
                cmplt_cnt = cur.gap;
                bstate = B_WAIT;
              end
            end
          end
        endcase
      end
    end else if (bstate == B_WAIT) begin
      checks++;
      if (bus_if.IP2Bus_MstWr_Req !== 1'b0) begin
        failures++;
        $display("FAIL wr_req_in_wait got=%b exp=0", bus_if.IP2Bus_MstWr_Req);
      end
      cmplt_cnt--;
      if (cmplt_cnt == 0) begin
        bus_if.Bus2IP_Mst_Cmplt = 1'b1;
        pixel_done();
        bstate = B_IDLE;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (n < budget && !(fifo_q.size() == 0 && exp_q.size() == 0 && !busy && bstate == B_IDLE));
    idle_t = cyc_n;
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout cycles=%0d exp_below=%0d", n, budget);
    end
  endtask

  task automatic clear_stats();
    rd_pulses = 0; rst_pulses = 0; wr_cycles = 0; attempts = 0;
    att_times.delete();
  endtask

  task automatic check_counters(input string tag);
    checks++;
    if (pix_written !== 32'(exp_written) || pix_dropped !== 16'(exp_dropped)) begin
      failures++;
      $display("FAIL %s_counters written=%0d dropped=%0d exp_written=%0d exp_dropped=%0d",
               tag, pix_written, pix_dropped, exp_written, exp_dropped);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b0 || bus_if.IP2Bus_MstWr_Req !== 1'b0 || fifo_rd_en !== 1'b0 ||
        bus_if.IP2Bus_Mst_Reset !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs busy=%b wr=%b rd=%b mrst=%b exp=0,0,0,1", busy,
               bus_if.IP2Bus_MstWr_Req, fifo_rd_en, bus_if.IP2Bus_Mst_Reset);
    end
    checks++;
    if (pix_written !== 32'd0 || pix_dropped !== 16'd0) begin
      failures++;
      $display("FAIL reset_counters written=%0d dropped=%0d exp=0", pix_written, pix_dropped);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus_if.IP2Bus_Mst_Reset !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset mrst=%b busy=%b exp=0,0", bus_if.IP2Bus_Mst_Reset, busy);
    end
  endtask

  task automatic test_single();
    clear_stats();
    pol_q.push_back('{K_OK, 2, 3});
    add_word(1'b1, 5, 7, 32'hDEADBEEF, 1'b0, 0, 0, 32'h0);
    drain(200);
    checks++;
    if (last_att_addr !== 32'h9000501C || last_att_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_addr_data addr=%h data=%h exp=9000501c/deadbeef", last_att_addr, last_att_data);
    end
    checks++;
    if (attempts !== 1 || wr_cycles !== 2 || rd_pulses !== 1) begin
      failures++;
      $display("FAIL single_shape attempts=%0d wr_cycles=%0d rd=%0d exp=1,2,1", attempts, wr_cycles, rd_pulses);
    end
    checks++;
    if (pix_written !== 32'd1) begin
      failures++;
      $display("FAIL single_written got=%0d exp=1", pix_written);
    end
    checks++;
    if (idle_t - last_cmplt_t !== 4) begin
      failures++;
      $display("FAIL single_busy_fall got=%0d exp=4", idle_t - last_cmplt_t);
    end
    check_counters("single");
  endtask

  task automatic test_back_to_back();
    clear_stats();
    add_word(1'b1, 1, 0, 32'h11112222, 1'b1, 1, 1, 32'h33334444);
    drain(200);
    checks++;
    if (attempts !== 2 || last_att_addr !== 32'h90001004) begin
      failures++;
      $display("FAIL b2b_requests attempts=%0d last_addr=%h exp=2/90001004", attempts, last_att_addr);
    end
    checks++;
    if (att_times.size() != 2 || att_times[1] - att_times[0] !== 3) begin
      failures++;
      $display("FAIL b2b_gap got=%0d exp=3", (att_times.size() == 2) ? att_times[1] - att_times[0] : -1);
    end
    check_counters("b2b");
  endtask

  task automatic test_clip();
    clear_stats();
    add_word(1'b1, 480, 0, 32'hAAAA0001, 1'b1, 0, 640, 32'hAAAA0002);
    add_word(1'b1, 479, 639, 32'hCAFEF00D, 1'b0, 600, 900, 32'hAAAA0003);
    drain(300);
    checks++;
    if (attempts !== 1 || wr_cycles !== 1 || last_att_addr !== 32'h901DF9FC) begin
      failures++;
      $display("FAIL clip_requests attempts=%0d wr_cycles=%0d addr=%h exp=1,1,901df9fc",
               attempts, wr_cycles, last_att_addr);
    end
    checks++;
    if (pix_dropped !== 16'd2) begin
      failures++;
      $display("FAIL clip_dropped got=%0d exp=2", pix_dropped);
    end
    check_counters("clip");
  endtask

  task automatic test_retry_once();
    clear_stats();
    pol_q.push_back('{K_ERR, 1, 0});
    add_word(1'b1, 10, 20, 32'h0BADC0DE, 1'b0, 0, 0, 32'h0);
    drain(200);
    checks++;
    if (attempts !== 2 || rst_pulses !== 1) begin
      failures++;
      $display("FAIL retry_once attempts=%0d mst_reset_cycles=%0d exp=2,1", attempts, rst_pulses);
    end
    check_counters("retry_once");
  endtask

  task automatic test_retry_exhaust();
    clear_stats();
    pol_q.push_back('{K_ERR, 1, 0});
    pol_q.push_back('{K_TO, 1, 0});
    pol_q.push_back('{K_ERR, 1, 0});
    pol_q.push_back('{K_TO, 1, 0});
    add_word(1'b1, 2, 3, 32'h01234567, 1'b1, 4, 5, 32'h89ABCDEF);
    drain(300);
    checks++;
    if (attempts !== 5 || rst_pulses !== 4 || last_att_addr !== 32'h90004014) begin
      failures++;
      $display("FAIL retry_exhaust attempts=%0d mst_reset_cycles=%0d last_addr=%h exp=5,4,90004014",
               attempts, rst_pulses, last_att_addr);
    end
    check_counters("retry_exhaust");
  endtask

  task automatic test_rearb();
    clear_stats();
    pol_q.push_back('{K_ERR, 1, 0});
    pol_q.push_back('{K_ERR, 1, 0});
    pol_q.push_back('{K_ERR, 1, 0});
    pol_q.push_back('{K_REARB, 1, 0});
    add_word(1'b1, 8, 9, 32'h5A5A5A5A, 1'b0, 0, 0, 32'h0);
    drain(300);
    checks++;
    if (attempts !== 5 || rst_pulses !== 3) begin
      failures++;
      $display("FAIL rearb_shape attempts=%0d mst_reset_cycles=%0d exp=5,3", attempts, rst_pulses);
    end
    checks++;
    if (att_times.size() != 5 || att_times[4] - att_times[3] !== 2) begin
      failures++;
      $display("FAIL rearb_gap got=%0d exp=2", (att_times.size() == 5) ? att_times[4] - att_times[3] : -1);
    end
    check_counters("rearb");
  endtask

  task automatic test_reset_midway();
    int n;
    clear_stats();
    pol_q.push_back('{K_OK, 1, 20});
    add_word(1'b1, 3, 3, 32'h77777777, 1'b1, 3, 4, 32'h88888888);
    n = 0;
    while (bstate != B_WAIT && n < 100) begin step(); n++; end
    checks++;
    if (bstate != B_WAIT) begin
      failures++;
      $display("FAIL midway_no_ack cycles=%0d exp_below=100", n);
    end
    step(); step();
    reset = 1'b1;
    step();
    bstate = B_IDLE; exp_q.delete(); pol_q.delete(); fails_in_row = 0;
    exp_written = 0; exp_dropped = 0;
    checks++;
    if (busy !== 1'b0 || bus_if.IP2Bus_MstWr_Req !== 1'b0 || bus_if.IP2Bus_Mst_Reset !== 1'b1) begin
      failures++;
      $display("FAIL midway_reset busy=%b wr=%b mrst=%b exp=0,0,1", busy,
               bus_if.IP2Bus_MstWr_Req, bus_if.IP2Bus_Mst_Reset);
    end
    check_counters("midway_reset");
    step();
    checks++;
    if (bus_if.IP2Bus_Mst_Reset !== 1'b1) begin
      failures++;
      $display("FAIL midway_mst_reset_hold got=%b exp=1", bus_if.IP2Bus_Mst_Reset);
    end
    reset = 1'b0;
    wr_cycles = 0;
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (wr_cycles !== 0 || busy !== 1'b0 || bus_if.IP2Bus_Mst_Reset !== 1'b0) begin
      failures++;
      $display("FAIL midway_abandon wr_cycles=%0d busy=%b mrst=%b exp=0,0,0", wr_cycles, busy,
               bus_if.IP2Bus_Mst_Reset);
    end
    check_counters("midway_after");
  endtask

  task automatic test_sat_counter();
    sc_rst = 1'b1; sc_inc = 1'b0;
    step();
    sc_rst = 1'b0; sc_inc = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (sc_count !== 4'd5) begin
      failures++;
      $display("FAIL sat_mid got=%0d exp=5", sc_count);
    end
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (sc_count !== 4'hF) begin
      failures++;
      $display("FAIL sat_hold got=%0d exp=15", sc_count);
    end
    sc_inc = 1'b0;
  endtask

  initial begin
    bus_if.Bus2IP_Mst_CmdAck = 1'b0;
    bus_if.Bus2IP_Mst_Cmplt = 1'b0;
    bus_if.Bus2IP_Mst_Error = 1'b0;
    bus_if.Bus2IP_Mst_Rearbitrate = 1'b0;
    bus_if.Bus2IP_Mst_Cmd_Timeout = 1'b0;
    bus_if.Bus2IP_MstRd_d = '0;
    bus_if.Bus2IP_MstRd_src_rdy_n = 1'b1;
    bus_if.Bus2IP_MstWr_dst_rdy_n = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_clip();
    test_retry_once();
    test_retry_exhaust();
    test_rearb();
    test_sat_counter();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
